// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    StWaitLo,
    StWaitHi,
    StData,
    StCheck,
    StDone,
    StError
  } loader_state_e;

  localparam int unsigned UartDataBits = 8;
  localparam int unsigned UartStopBits = 1;

  localparam int unsigned SysClkHz = 40_000_000;
  localparam int unsigned UartBaud = 115_200;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  localparam int unsigned DefaultClksPerBit = clks_per_bit(SysClkHz, UartBaud);

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle rx_valid/rx_frame_err.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] DataIdxLast = 3'(UartDataBits - 1);
  localparam logic [2:0] StopIdxLast = 3'(UartStopBits - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       state_q, state_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RxIdle;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_serial};
      prev_q  <= rx_s;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (prev_q && !rx_s) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          // Start bit gone high by mid-bit: treat as a glitch, not a frame.
          state_d = rx_s ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == DataIdxLast) begin
            idx_d   = '0;
            state_d = RxStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = RxIdle;
          end else if (idx_q == StopIdxLast) begin
            valid_d = 1'b1;
            state_d = RxIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign rx_data      = shift_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives count + words + XOR checksum over UART, writes imem, releases core reset.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned ADDRESS_SIZE = 10,
  parameter int unsigned N            = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_serial,
  input  logic                    reload,
  output logic                    imem_wr_en,
  output logic [ADDRESS_SIZE-1:0] imem_wr_addr,
  output logic [N-1:0]            imem_wr_data,
  output logic                    core_rst_n,
  output logic                    load_done,
  output logic                    load_error
);

  localparam int unsigned IdxW = ADDRESS_SIZE - 2;
  localparam logic [16:0] Capacity = 17'(2 ** IdxW);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  loader_state_e          state_q, state_d;
  logic [7:0]             count_lo_q, count_lo_d;
  logic [15:0]            remaining_q, remaining_d;
  logic [IdxW-1:0]        index_q, index_d;
  logic [1:0]             lane_q, lane_d;
  logic [N-1:0]           word_q, word_d;
  logic [7:0]             xor_q, xor_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDRESS_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0]           wr_data_q, wr_data_d;
  logic                   core_rst_n_q, done_q, err_q;
  logic [15:0]            count_full;
  logic [N-1:0]           assembled;

  assign count_full = {rx_data, count_lo_q};
  // Little-endian: each new byte enters at the top, so lane 0 ends up in the LSBs.
  assign assembled  = {rx_data, word_q[N-1:8]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StWaitLo;
      count_lo_q   <= '0;
      remaining_q  <= '0;
      index_q      <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      xor_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_lo_q   <= count_lo_d;
      remaining_q  <= remaining_d;
      index_q      <= index_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      xor_q        <= xor_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_rst_n_q <= (state_d == StDone);
      done_q       <= (state_d == StDone);
      err_q        <= (state_d == StError);
    end
  end

  always_comb begin
    state_d     = state_q;
    count_lo_d  = count_lo_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    lane_d      = lane_q;
    word_d      = word_q;
    xor_d       = xor_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      StWaitLo: begin
        if (rx_frame_err) begin
          state_d = StError;
        end else if (rx_valid) begin
          count_lo_d = rx_data;
          state_d    = StWaitHi;
        end
      end
      StWaitHi: begin
        if (rx_frame_err) begin
          state_d = StError;
        end else if (rx_valid) begin
          if ({1'b0, count_full} > Capacity) begin
            state_d = StError;
          end else if (count_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            remaining_d = count_full;
            state_d     = StData;
          end
        end
      end
      StData: begin
        if (rx_frame_err) begin
          state_d = StError;
        end else if (rx_valid) begin
          xor_d  = xor_q ^ rx_data;
          word_d = assembled;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = {index_q, 2'b00};
            wr_data_d   = assembled;
            index_d     = index_q + IdxW'(1);
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (rx_frame_err) begin
          state_d = StError;
        end else if (rx_valid) begin
          state_d = (rx_data == xor_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        if (reload) begin
          count_lo_d  = '0;
          remaining_d = '0;
          index_d     = '0;
          lane_d      = '0;
          xor_d       = '0;
          state_d     = StWaitLo;
        end
      end
      default: state_d = StWaitLo;
    endcase
  end

  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign core_rst_n   = core_rst_n_q;
  assign load_done    = done_q;
  assign load_error   = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed table-driven bench for imem_uart_loader at 8 clocks per UART bit.
module tb_imem_uart_loader;
  import imem_uart_loader_pkg::*;

  localparam int unsigned Cpb = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_serial;
  logic        reload;
  logic        imem_wr_en;
  logic [9:0]  imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        core_rst_n;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .CLKS_PER_BIT(Cpb),
    .ADDRESS_SIZE(10),
    .N           (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .reload      (reload),
    .imem_wr_en  (imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .core_rst_n  (core_rst_n),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  typedef struct packed {
    logic [95:0] bytes;      // byte i at bits [i*8 +: 8]
    logic [7:0]  nbytes;
    logic [7:0]  bad_stop;   // index of byte sent with a low stop bit, 8'hFF for none
    logic [7:0]  exp_writes;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  int cyc = 0;
  int last_ev = 0;
  int stat_lat = -1;
  int early_rel = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;
  logic flag_prev = 1'b0;
  logic [9:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_lat[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.rx_valid || dut.rx_frame_err) last_ev = cyc;
    if (dut.rx_valid) rxv_cnt++;
    if (dut.rx_frame_err) ferr_cnt++;
    if (imem_wr_en) begin
      wq_addr.push_back(imem_wr_addr);
      wq_data.push_back(imem_wr_data);
      wq_lat.push_back(cyc - last_ev);
    end
    if ((load_done || load_error) && !flag_prev) stat_lat = cyc - last_ev;
    flag_prev = load_done || load_error;
    if (core_rst_n && !load_done) early_rel++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx_serial = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      tick(Cpb);
    end
    rx_serial = stop_ok;
    tick(Cpb);
    rx_serial = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wr_en"}, 64'(imem_wr_en), 64'd0);
    check({tag, " wr_addr"}, 64'(imem_wr_addr), 64'd0);
    check({tag, " wr_data"}, 64'(imem_wr_data), 64'd0);
    check({tag, " core_rst_n"}, 64'(core_rst_n), 64'd0);
    check({tag, " load_done"}, 64'(load_done), 64'd0);
    check({tag, " load_error"}, 64'(load_error), 64'd0);
  endtask

  task automatic pulse_reload(input string tag);
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
    check({tag, " reload core_rst_n"}, 64'(core_rst_n), 64'd0);
    check({tag, " reload done"}, 64'(load_done), 64'd0);
    check({tag, " reload error"}, 64'(load_error), 64'd0);
  endtask

  task automatic run_vec(input vec_t vc, input string tag);
    logic [95:0] bs;
    logic [31:0] exp_word;
    bs = vc.bytes;
    wq_addr.delete();
    wq_data.delete();
    wq_lat.delete();
    stat_lat  = -1;
    early_rel = 0;
    for (int i = 0; i < int'(vc.nbytes); i++) begin
      send_byte(bs[i*8 +: 8], (vc.bad_stop != 8'(i)));
    end
    tick(20);
    check({tag, " nwrites"}, 64'(wq_addr.size()), 64'(vc.exp_writes));
    for (int k = 0; k < int'(vc.exp_writes); k++) begin
      if (k < wq_addr.size()) begin
        exp_word = {bs[(5 + 4*k)*8 +: 8], bs[(4 + 4*k)*8 +: 8],
                    bs[(3 + 4*k)*8 +: 8], bs[(2 + 4*k)*8 +: 8]};
        check($sformatf("%s wr%0d addr", tag, k), 64'(wq_addr[k]), 64'(4 * k));
        check($sformatf("%s wr%0d data", tag, k), 64'(wq_data[k]), 64'(exp_word));
        check($sformatf("%s wr%0d latency", tag, k), 64'(wq_lat[k]), 64'd1);
      end
    end
    check({tag, " load_done"}, 64'(load_done), 64'(vc.exp_done));
    check({tag, " load_error"}, 64'(load_error), 64'(vc.exp_err));
    check({tag, " core_rst_n"}, 64'(core_rst_n), 64'(vc.exp_done));
    check({tag, " status latency"}, 64'(stat_lat), 64'd1);
    check({tag, " early release"}, 64'(early_rel), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vec_t boot;
    int   rv0;
    int   fe0;

    // Checksum of 13 05 10 00 93 05 20 00 is 0xB0.
    boot = '{bytes: 96'h00_B0_00_20_05_93_00_10_05_13_00_02, nbytes: 8'd11,
             bad_stop: 8'hFF, exp_writes: 8'd2, exp_done: 1'b1, exp_err: 1'b0};
    vecs[0] = boot;
    vecs[1] = '{bytes: 96'h00_00_00, nbytes: 8'd3, bad_stop: 8'hFF,
                exp_writes: 8'd0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{bytes: 96'h01_00_00, nbytes: 8'd3, bad_stop: 8'hFF,
                exp_writes: 8'd0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{bytes: 96'h01_01, nbytes: 8'd2, bad_stop: 8'hFF,
                exp_writes: 8'd0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[4] = '{bytes: 96'h05_13_00_02, nbytes: 8'd4, bad_stop: 8'd3,
                exp_writes: 8'd0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = boot;

    reset     = 1'b0;
    rx_serial = 1'b1;
    reload    = 1'b0;
    tick(3);
    check_reset_outputs("por");
    reset = 1'b1;
    tick(2);

    for (int v = 0; v < 6; v++) begin
      if (v > 0) pulse_reload($sformatf("v%0d", v));
      run_vec(vecs[v], $sformatf("v%0d", v));
    end

    // Short low glitch on an idle line must not start a frame.
    pulse_reload("glitch");
    rv0 = rxv_cnt;
    fe0 = ferr_cnt;
    rx_serial = 1'b0;
    tick(3);
    rx_serial = 1'b1;
    tick(30);
    check("glitch rx_valid", 64'(rxv_cnt), 64'(rv0));
    check("glitch frame_err", 64'(ferr_cnt), 64'(fe0));
    check("glitch state", 64'(dut.state_q), 64'(StWaitLo));
    check("glitch load_error", 64'(load_error), 64'd0);

    // Reset in the middle of DATA after one word has been written.
    wq_addr.delete();
    wq_data.delete();
    wq_lat.delete();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(10);
    check("middata nwrites", 64'(wq_addr.size()), 64'd1);
    check("middata wr_data", 64'(imem_wr_data), 64'h0010_0513);
    rx_serial = 1'b0;
    tick(20);
    reset = 1'b0;
    #2;
    check_reset_outputs("middata");
    check("middata state", 64'(dut.state_q), 64'(StWaitLo));
    rx_serial = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(3);
    run_vec(boot, "postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
